spi_bus_arbiter: RTL and testbench

Shares the single on-board SPI bus between three requesters: the preamp gain programmer, the ADC sampler and the DAC writer. Grants exactly one owner at a time and inserts a guard gap between owners. Holds the other SPI-bus devices (serial flash, StrataFlash, platform flash) permanently deselected. Sits between the effect-chain sequencing logic and the SPI shift engines, replacing free-running enable timing with request/grant.

---
 rtl/spi_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Request/grant arbiter for the shared on-board SPI bus. It serves the gain programmer, the ADC
// sampler and the DAC writer, inserts a guard gap between owners and keeps the flash parts deselected.
module spi_bus_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 127
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_gain,
    input  logic       req_adc,
    input  logic       req_dac,
    input  logic       done_gain,
    input  logic       done_adc,
    input  logic       done_dac,
    output logic       enablegain,
    output logic       enableadc,
    output logic       enabledac,
    output logic       spissb,
    output logic       sf_ce0,
    output logic       fpgainitb,
    output logic       gain_ok,
    output logic       timeout_err,
    output logic [6:0] contador
);

    localparam logic [6:0] TimeoutVal = 7'(TIMEOUT_CYCLES);
    localparam logic [3:0] GuardLast  = 4'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StOwnGain,
        StOwnAdc,
        StOwnDac,
        StGuard
    } state_e;

    state_e     state_q, state_d;
    logic       rr_dac_q, rr_dac_d;  // 1: DAC wins an ADC/DAC tie
    logic [3:0] guard_q, guard_d;
    logic [6:0] cnt_q, cnt_d;
    logic       gain_ok_q, gain_ok_d;
    logic       timeout_q, timeout_d;
    logic       en_gain_q, en_adc_q, en_dac_q;
    logic [2:0] flash_q;
    logic       adc_elig;
    logic       own_next;

    assign adc_elig = req_adc & gain_ok_q;

    always_comb begin
        state_d   = state_q;
        rr_dac_d  = rr_dac_q;
        guard_d   = guard_q;
        gain_ok_d = gain_ok_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (req_gain) begin
                    state_d = StOwnGain;
                end else if (adc_elig && req_dac) begin
                    state_d = rr_dac_q ? StOwnDac : StOwnAdc;
                end else if (adc_elig) begin
                    state_d = StOwnAdc;
                end else if (req_dac) begin
                    state_d = StOwnDac;
                end
            end
            StOwnGain: begin
                if (done_gain) begin
                    gain_ok_d = 1'b1;
                    state_d   = StGuard;
                end else if (!req_gain) begin
                    state_d = StGuard;
                end else if (cnt_q == TimeoutVal) begin
                    timeout_d = 1'b1;
                    state_d   = StGuard;
                end
            end
            StOwnAdc: begin
                if (done_adc || !req_adc) begin
                    state_d = StGuard;
                end else if (cnt_q == TimeoutVal) begin
                    timeout_d = 1'b1;
                    state_d   = StGuard;
                end
                if (state_d == StGuard) begin
                    rr_dac_d = 1'b1;
                end
            end
            StOwnDac: begin
                if (done_dac || !req_dac) begin
                    state_d = StGuard;
                end else if (cnt_q == TimeoutVal) begin
                    timeout_d = 1'b1;
                    state_d   = StGuard;
                end
                if (state_d == StGuard) begin
                    rr_dac_d = 1'b0;
                end
            end
            StGuard: begin
                if (guard_q == GuardLast) begin
                    state_d = StIdle;
                end else begin
                    guard_d = guard_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StGuard && state_q != StGuard) begin
            guard_d = 4'd0;
        end

        own_next = (state_d == StOwnGain) || (state_d == StOwnAdc) || (state_d == StOwnDac);
        if (!own_next) begin
            cnt_d = 7'd0;
        end else if (state_q == StIdle) begin
            cnt_d = 7'd1;
        end else if (cnt_q != 7'h7f) begin
            cnt_d = cnt_q + 7'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            rr_dac_q  <= 1'b0;
            guard_q   <= 4'd0;
            cnt_q     <= 7'd0;
            gain_ok_q <= 1'b0;
            timeout_q <= 1'b0;
            en_gain_q <= 1'b0;
            en_adc_q  <= 1'b0;
            en_dac_q  <= 1'b0;
            flash_q   <= 3'b111;
        end else begin
            state_q   <= state_d;
            rr_dac_q  <= rr_dac_d;
            guard_q   <= guard_d;
            cnt_q     <= cnt_d;
            gain_ok_q <= gain_ok_d;
            timeout_q <= timeout_d;
            en_gain_q <= (state_d == StOwnGain);
            en_adc_q  <= (state_d == StOwnAdc);
            en_dac_q  <= (state_d == StOwnDac);
            flash_q   <= 3'b111;
        end
    end

    assign enablegain  = en_gain_q;
    assign enableadc   = en_adc_q;
    assign enabledac   = en_dac_q;
    assign spissb      = flash_q[2];
    assign sf_ce0      = flash_q[1];
    assign fpgainitb   = flash_q[0];
    assign gain_ok     = gain_ok_q;
    assign timeout_err = timeout_q;
    assign contador    = cnt_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: expected grant owners are queued as requests are
// raised and popped by a monitor whenever a new enable rises.
module tb_spi_bus_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_gain, req_adc, req_dac;
    logic       done_gain, done_adc, done_dac;
    logic       enablegain, enableadc, enabledac;
    logic       spissb, sf_ce0, fpgainitb;
    logic       gain_ok, timeout_err;
    logic [6:0] contador;

    localparam logic [2:0] OwnGain = 3'b100;
    localparam logic [2:0] OwnAdc  = 3'b010;
    localparam logic [2:0] OwnDac  = 3'b001;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [2:0]  exp_q[$];
    logic        mon_en   = 1'b0;
    logic [2:0]  prev_en  = 3'b000;
    int          ticks;

    spi_bus_arbiter #(
        .GUARD_CYCLES  (4),
        .TIMEOUT_CYCLES(127)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_gain   (req_gain),
        .req_adc    (req_adc),
        .req_dac    (req_dac),
        .done_gain  (done_gain),
        .done_adc   (done_adc),
        .done_dac   (done_dac),
        .enablegain (enablegain),
        .enableadc  (enableadc),
        .enabledac  (enabledac),
        .spissb     (spissb),
        .sf_ce0     (sf_ce0),
        .fpgainitb  (fpgainitb),
        .gain_ok    (gain_ok),
        .timeout_err(timeout_err),
        .contador   (contador)
    );

    always #5 clock = ~clock;

    wire [2:0] en_vec = {enablegain, enableadc, enabledac};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits for any enable to rise; ticks counts edges from the call.
    task automatic wait_grant(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            n++;
            if (en_vec != 3'b000) break;
        end
        if (en_vec == 3'b000) check_val("grant_timeout", 32'(en_vec), 32'd1);
    endtask

    // Pulses the owner's done while contador shows n, then checks the release.
    task automatic hold_done(input logic [2:0] owner, input int n);
        repeat (n - 1) tick();
        check_val("hold_count", 32'(contador), 32'(n));
        check_val("hold_owner", 32'(en_vec), 32'(owner));
        done_gain = owner[2];
        done_adc  = owner[1];
        done_dac  = owner[0];
        tick();
        done_gain = 1'b0;
        done_adc  = 1'b0;
        done_dac  = 1'b0;
        check_val("release_en", 32'(en_vec), 32'd0);
        check_val("release_cnt", 32'(contador), 32'd0);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            check_val("one_hot", 32'($countones(en_vec) <= 1), 32'd1);
            check_val("flash_sel", 32'({spissb, sf_ce0, fpgainitb}), 32'h7);
            if (prev_en == 3'b000 && en_vec != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_grant", 32'(en_vec), 32'd0);
                end else begin
                    check_val("grant_owner", 32'(en_vec), 32'(exp_q.pop_front()));
                end
            end
            prev_en = en_vec;
        end
    end

    initial begin
        reset = 1'b1;
        {req_gain, req_adc, req_dac}    = 3'b000;
        {done_gain, done_adc, done_dac} = 3'b000;
        repeat (3) tick();
        mon_en = 1'b1;
        check_val("rst_en", 32'(en_vec), 32'd0);
        check_val("rst_gain_ok", 32'(gain_ok), 32'd0);
        check_val("rst_timeout", 32'(timeout_err), 32'd0);
        check_val("rst_cnt", 32'(contador), 32'd0);
        reset = 1'b0;

        // ADC is not eligible until gain is programmed
        req_adc = 1'b1;
        repeat (30) tick();
        check_val("adc_blocked", 32'(enableadc), 32'd0);
        req_gain = 1'b1;
        exp_q.push_back(OwnGain);
        exp_q.push_back(OwnAdc);
        tick();
        check_val("gain_latency", 32'(enablegain), 32'd1);
        check_val("gain_cnt1", 32'(contador), 32'd1);
        hold_done(OwnGain, 20);
        req_gain = 1'b0;
        check_val("gain_ok_set", 32'(gain_ok), 32'd1);
        wait_grant(20, ticks);
        check_val("guard_gain_adc", 32'(ticks), 32'd5);

        // ADC and DAC both pending: alternate
        req_dac = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [2:0] cur;
            cur = (i % 2 == 0) ? OwnAdc : OwnDac;
            exp_q.push_back((i % 2 == 0) ? OwnDac : OwnAdc);
            hold_done(cur, 10);
            wait_grant(20, ticks);
            check_val("rr_gap", 32'(ticks), 32'd5);
        end
        req_adc = 1'b0;
        req_dac = 1'b0;
        tick();
        check_val("drop_release", 32'(en_vec), 32'd0);
        repeat (10) tick();

        // Gain beats DAC
        req_gain = 1'b1;
        req_dac  = 1'b1;
        exp_q.push_back(OwnGain);
        exp_q.push_back(OwnDac);
        wait_grant(5, ticks);
        check_val("gain_first_lat", 32'(ticks), 32'd1);
        hold_done(OwnGain, 5);
        req_gain = 1'b0;
        wait_grant(20, ticks);
        check_val("dac_after_gain", 32'(ticks), 32'd5);

        // done exactly at the watchdog limit wins
        repeat (126) tick();
        check_val("dac_cnt127", 32'(contador), 32'd127);
        done_dac = 1'b1;
        tick();
        done_dac = 1'b0;
        check_val("done_at_limit_en", 32'(enabledac), 32'd0);
        check_val("done_at_limit_err", 32'(timeout_err), 32'd0);
        exp_q.push_back(OwnDac);
        wait_grant(20, ticks);
        check_val("dac_regrant", 32'(ticks), 32'd5);

        // Watchdog revokes a silent owner
        repeat (126) tick();
        check_val("wd_pre_en", 32'(enabledac), 32'd1);
        check_val("wd_pre_err", 32'(timeout_err), 32'd0);
        tick();
        req_dac = 1'b0;
        check_val("wd_en", 32'(enabledac), 32'd0);
        check_val("wd_err", 32'(timeout_err), 32'd1);
        check_val("wd_cnt", 32'(contador), 32'd0);
        repeat (10) tick();
        check_val("wd_sticky", 32'(timeout_err), 32'd1);

        // Spurious done from a non-owner, then release by request drop
        req_adc = 1'b1;
        exp_q.push_back(OwnAdc);
        wait_grant(5, ticks);
        check_val("adc_lat", 32'(ticks), 32'd1);
        repeat (2) tick();
        done_dac = 1'b1;
        tick();
        done_dac = 1'b0;
        check_val("spurious_owner", 32'(en_vec), 32'(OwnAdc));
        check_val("spurious_cnt", 32'(contador), 32'd4);
        tick();
        check_val("drop_at5_cnt", 32'(contador), 32'd5);
        req_adc = 1'b0;
        tick();
        check_val("drop_at5_en", 32'(en_vec), 32'd0);
        check_val("drop_at5_rel", 32'(contador), 32'd0);
        repeat (10) tick();

        // Reset while the ADC owns the bus
        req_adc = 1'b1;
        exp_q.push_back(OwnAdc);
        wait_grant(5, ticks);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check_val("midrst_en", 32'(en_vec), 32'd0);
        check_val("midrst_gain_ok", 32'(gain_ok), 32'd0);
        check_val("midrst_err", 32'(timeout_err), 32'd0);
        check_val("midrst_cnt", 32'(contador), 32'd0);
        reset = 1'b0;
        repeat (20) tick();
        check_val("post_rst_adc_blocked", 32'(enableadc), 32'd0);
        req_adc = 1'b0;
        tick();

        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
